// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared widths, instruction fields and op-class encoding for the ID stage
package decode_stage_pkg;

  localparam int WORD   = 32;
  localparam int W_RD   = 4;
  localparam int ADDR   = 16;
  localparam int W_DOPC = 12;
  localparam int W_OPC  = 6;
  localparam int W_CC   = 4;
  localparam int NREG   = 1 << W_RD;

  // Instruction field bit ranges
  localparam int F_OPC_HI  = 31;
  localparam int F_OPC_LO  = 26;
  localparam int F_RD_HI   = 25;
  localparam int F_RD_LO   = 22;
  localparam int F_RS_HI   = 21;
  localparam int F_RS_LO   = 18;
  localparam int F_MODE_HI = 17;
  localparam int F_MODE_LO = 16;
  localparam int F_IMM_HI  = 15;
  localparam int F_IMM_LO  = 0;
  localparam int W_IMM     = F_IMM_HI - F_IMM_LO + 1;

  // Operand mode; reserved encodings behave as register mode
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b01;

  // Op classes in the order EX expects them; class N drives dopc bit W_DOPC-1-N
  typedef enum logic [3:0] {
    CLS_ADDSUB = 4'd0,
    CLS_MUL    = 4'd1,
    CLS_DIV    = 4'd2,
    CLS_ABS    = 4'd3,
    CLS_SHIFT  = 4'd4,
    CLS_LOGIC  = 4'd5,
    CLS_SET    = 4'd6,
    CLS_LOAD   = 4'd7,
    CLS_STORE  = 4'd8,
    CLS_JUMP   = 4'd9,
    CLS_NOP    = 4'd10,
    CLS_HALT   = 4'd11
  } op_class_e;

  localparam logic [W_DOPC-1:0] DOPC_NOP  = W_DOPC'(1) << (W_DOPC - 1 - int'(CLS_NOP));
  localparam logic [W_DOPC-1:0] DOPC_HALT = W_DOPC'(1) << (W_DOPC - 1 - int'(CLS_HALT));

  // Fold unused class codes onto nop so EX never sees an undefined class
  function automatic logic [3:0] effective_class(input logic [3:0] cls);
    return (cls > 4'(CLS_HALT)) ? 4'(CLS_NOP) : cls;
  endfunction

  function automatic logic [W_DOPC-1:0] dopc_onehot(input logic [3:0] cls);
    return W_DOPC'(1) << (W_DOPC - 1 - int'(cls));
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 16x32 register file, two bypassed combinational reads, one write, r0 hardwired to zero
module regfile_2r1w
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [W_RD-1:0] wa,
  input  logic [WORD-1:0] wd,
  input  logic [W_RD-1:0] ra_a,
  output logic [WORD-1:0] rd_a,
  input  logic [W_RD-1:0] ra_b,
  output logic [WORD-1:0] rd_b
);

  logic [WORD-1:0] mem [NREG];

  // Write port: r0 is never written so it keeps its cleared value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Read port A: zero for r0, same-cycle write data forwarded ahead of the array
  always_comb begin
    rd_a = mem[ra_a];
    if (ra_a == '0)                rd_a = '0;
    else if (we && (wa == ra_a))   rd_a = wd;
  end

  // Read port B: same forwarding rules as port A
  always_comb begin
    rd_b = mem[ra_b];
    if (ra_b == '0)                rd_b = '0;
    else if (we && (wa == ra_b))   rd_b = wd;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, operand read, RAW bubble, halt/stall/flush handling
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [WORD-1:0]   inst_i,
  input  logic [ADDR-1:0]   addr_i,
  output logic              stall_o,
  input  logic              branch_i,
  input  logic              stall_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wr_num_i,
  input  logic [WORD-1:0]   wr_data_i,
  output logic              v_o,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  output logic [W_CC-1:0]   cc_o
);

  logic [W_OPC-1:0]  opc;
  logic [W_RD-1:0]   rd;
  logic [W_RD-1:0]   rs;
  logic [1:0]        mode;
  logic [W_IMM-1:0]  imm;
  logic [3:0]        cls;
  logic [W_DOPC-1:0] dopc;
  logic              wb;
  logic              is_halt;
  logic [WORD-1:0]   rs_data;
  logic [WORD-1:0]   rd_data;
  logic [WORD-1:0]   src;
  logic              hz;
  logic              halted;

  assign opc  = inst_i[F_OPC_HI:F_OPC_LO];
  assign rd   = inst_i[F_RD_HI:F_RD_LO];
  assign rs   = inst_i[F_RS_HI:F_RS_LO];
  assign mode = inst_i[F_MODE_HI:F_MODE_LO];
  assign imm  = inst_i[F_IMM_HI:F_IMM_LO];

  regfile_2r1w u_rf (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_i),
    .wa   (wr_num_i),
    .wd   (wr_data_i),
    .ra_a (rs),
    .rd_a (rs_data),
    .ra_b (rd),
    .rd_b (rd_data)
  );

  // Decode the instruction in ID and detect a RAW dependency on the one in EX
  always_comb begin
    cls     = effective_class(opc[W_OPC-1:2]);
    dopc    = dopc_onehot(cls);
    wb      = (cls <= 4'(CLS_LOAD)) && (rd != '0);
    is_halt = (cls == 4'(CLS_HALT));
    src     = (mode == MODE_IMM) ? {{(WORD-W_IMM){imm[W_IMM-1]}}, imm} : rs_data;
    hz      = v_i && v_o && wb_o && (rd_num_o != '0) &&
              ((rd_num_o == rd) || ((mode != MODE_IMM) && (rd_num_o == rs)));
  end

  assign stall_o = stall_i | halted | (hz & ~branch_i);

  // EX input register: hold on EX stall, bubble on halt/flush/hazard, else take the decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_o        <= 1'b0;
      src_o      <= '0;
      dest_o     <= '0;
      wb_o       <= 1'b0;
      rd_num_o   <= '0;
      dopc_o     <= '0;
      opc_o      <= '0;
      origaddr_o <= '0;
      cc_o       <= '0;
      halted     <= 1'b0;
    end else if (!stall_i) begin
      if (halted || branch_i || hz) begin
        v_o    <= 1'b0;
        wb_o   <= 1'b0;
        dopc_o <= DOPC_NOP;
      end else begin
        v_o        <= v_i;
        src_o      <= src;
        dest_o     <= rd_data;
        wb_o       <= wb & v_i;
        rd_num_o   <= rd;
        dopc_o     <= dopc;
        opc_o      <= opc;
        origaddr_o <= addr_i;
        cc_o       <= rd;
        if (v_i && is_halt) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed instruction vectors
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic [31:0] inst_i;
  logic [15:0] addr_i;
  logic        stall_o;
  logic        branch_i;
  logic        stall_i;
  logic        wb_i;
  logic [3:0]  wr_num_i;
  logic [31:0] wr_data_i;
  logic        v_o;
  logic [31:0] src_o;
  logic [31:0] dest_o;
  logic        wb_o;
  logic [3:0]  rd_num_o;
  logic [11:0] dopc_o;
  logic [5:0]  opc_o;
  logic [15:0] origaddr_o;
  logic [3:0]  cc_o;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dest;
    logic        wb;
    logic [3:0]  rd;
    logic [11:0] dopc;
    logic [5:0]  opc;
    logic [15:0] addr;
    logic [3:0]  cc;
  } out_t;

  out_t q[$];
  int   checks = 0;
  int   errors = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .v_i        (v_i),
    .inst_i     (inst_i),
    .addr_i     (addr_i),
    .stall_o    (stall_o),
    .branch_i   (branch_i),
    .stall_i    (stall_i),
    .wb_i       (wb_i),
    .wr_num_i   (wr_num_i),
    .wr_data_i  (wr_data_i),
    .v_o        (v_o),
    .src_o      (src_o),
    .dest_o     (dest_o),
    .wb_o       (wb_o),
    .rd_num_o   (rd_num_o),
    .dopc_o     (dopc_o),
    .opc_o      (opc_o),
    .origaddr_o (origaddr_o),
    .cc_o       (cc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [1:0] mode,
                                     input logic [15:0] imm);
    return {opc, rd, rs, mode, imm};
  endfunction

  task automatic issue(input logic [31:0] inst, input logic [15:0] addr);
    v_i    = 1'b1;
    inst_i = inst;
    addr_i = addr;
  endtask

  task automatic expect_out(input logic [31:0] src, input logic [31:0] dest, input logic wb,
                            input logic [3:0] rd, input logic [11:0] dopc, input logic [5:0] opc,
                            input logic [15:0] addr, input logic [3:0] cc);
    q.push_back('{src: src, dest: dest, wb: wb, rd: rd, dopc: dopc, opc: opc, addr: addr, cc: cc});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: every freshly loaded valid output is matched against the head of the scoreboard
  initial begin
    logic acc;
    out_t act;
    out_t req;
    forever begin
      @(posedge clk);
      acc = rst && !stall_i;
      @(negedge clk);
      if (v_o && acc) begin
        act = '{src: src_o, dest: dest_o, wb: wb_o, rd: rd_num_o, dopc: dopc_o,
                opc: opc_o, addr: origaddr_o, cc: cc_o};
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_v_o actual=%h required=none", act);
        end else begin
          req = q.pop_front();
          chk($sformatf("out_%04h", req.addr), 128'(act), 128'(req));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; v_i = 1'b0; inst_i = '0; addr_i = '0; branch_i = 1'b0; stall_i = 1'b0;
    wb_i = 1'b0; wr_num_i = '0; wr_data_i = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_v_o", v_o, 0);
    chk("rst_wb_o", wb_o, 0);
    chk("rst_src_o", src_o, 0);
    chk("rst_dopc_o", dopc_o, 0);
    chk("rst_stall_o", stall_o, 0);
    cyc();
    rst = 1'b1;

    // addsub immediate, all-ones immediate sign-extends
    issue(mk(6'h00, 4'd1, 4'd0, 2'b01, 16'hFFFF), 16'h0100);
    expect_out(32'hFFFF_FFFF, 32'h0, 1'b1, 4'd1, 12'h800, 6'h00, 16'h0100, 4'd1);
    settle(); chk("stall_first", stall_o, 0);
    cyc();

    // I1 writes r2
    issue(mk(6'h00, 4'd2, 4'd0, 2'b01, 16'h0005), 16'h0104);
    expect_out(32'h5, 32'h0, 1'b1, 4'd2, 12'h800, 6'h00, 16'h0104, 4'd2);
    cyc();

    // I2 reads r2 in register mode: one bubble, then value via bypass
    issue(mk(6'h00, 4'd4, 4'd2, 2'b00, 16'h0000), 16'h0108);
    settle(); chk("stall_raw", stall_o, 1);
    cyc();
    chk("bubble_v_o", v_o, 0);
    chk("bubble_wb_o", wb_o, 0);
    chk("bubble_dopc", dopc_o, 12'h002);
    wb_i = 1'b1; wr_num_i = 4'd2; wr_data_i = 32'h1234;
    expect_out(32'h1234, 32'h0, 1'b1, 4'd4, 12'h800, 6'h00, 16'h0108, 4'd4);
    settle(); chk("stall_after_bubble", stall_o, 0);
    cyc();

    // store reading r3 as rd while r3 is written the same cycle
    wr_num_i = 4'd3; wr_data_i = 32'hCAFE;
    issue(mk(6'h20, 4'd3, 4'd2, 2'b00, 16'h0000), 16'h010C);
    expect_out(32'h1234, 32'hCAFE, 1'b0, 4'd3, 12'h008, 6'h20, 16'h010C, 4'd3);
    cyc();

    // write to r0 must not forward nor stick
    wr_num_i = 4'd0; wr_data_i = 32'hDEAD;
    issue(mk(6'h01, 4'd5, 4'd0, 2'b00, 16'h0000), 16'h0110);
    expect_out(32'h0, 32'h0, 1'b1, 4'd5, 12'h800, 6'h01, 16'h0110, 4'd5);
    cyc();
    wb_i = 1'b0;
    issue(mk(6'h15, 4'd0, 4'd0, 2'b00, 16'h0000), 16'h0114);
    expect_out(32'h0, 32'h0, 1'b0, 4'd0, 12'h040, 6'h15, 16'h0114, 4'd0);
    cyc();

    // class 15 decodes as nop; r3 holds the committed 0xCAFE
    issue(mk(6'h3C, 4'd3, 4'd3, 2'b00, 16'h0000), 16'h0118);
    expect_out(32'hCAFE, 32'hCAFE, 1'b0, 4'd3, 12'h002, 6'h3C, 16'h0118, 4'd3);
    cyc();

    // plain flush
    issue(mk(6'h00, 4'd6, 4'd0, 2'b01, 16'h8000), 16'h011C);
    branch_i = 1'b1;
    settle(); chk("stall_branch", stall_o, 0);
    cyc();
    chk("flush_v_o", v_o, 0);
    branch_i = 1'b0;

    // flush wins over a hazard
    issue(mk(6'h00, 4'd7, 4'd0, 2'b01, 16'h0001), 16'h0120);
    expect_out(32'h1, 32'h0, 1'b1, 4'd7, 12'h800, 6'h00, 16'h0120, 4'd7);
    cyc();
    issue(mk(6'h00, 4'd8, 4'd7, 2'b00, 16'h0000), 16'h0124);
    branch_i = 1'b1;
    settle(); chk("stall_hz_branch", stall_o, 0);
    cyc();
    chk("flush_hz_v_o", v_o, 0);
    branch_i = 1'b0;

    // EX stall for three cycles holds the registered mul
    issue(mk(6'h04, 4'd9, 4'd0, 2'b01, 16'h0010), 16'h0130);
    expect_out(32'h10, 32'h0, 1'b1, 4'd9, 12'h400, 6'h04, 16'h0130, 4'd9);
    cyc();
    issue(mk(6'h24, 4'hA, 4'd0, 2'b01, 16'h0002), 16'h0134);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk($sformatf("stall_i_%0d", i), stall_o, 1);
      cyc();
      chk($sformatf("hold_v_%0d", i), v_o, 1);
      chk($sformatf("hold_src_%0d", i), src_o, 32'h10);
      chk($sformatf("hold_addr_%0d", i), origaddr_o, 16'h0130);
    end
    stall_i = 1'b0;
    expect_out(32'h2, 32'h0, 1'b0, 4'hA, 12'h004, 6'h24, 16'h0134, 4'hA);
    settle(); chk("stall_release", stall_o, 0);
    cyc();

    // halt: one valid cycle then permanently stalled
    issue(mk(6'h2C, 4'd0, 4'd0, 2'b01, 16'h0000), 16'h0138);
    expect_out(32'h0, 32'h0, 1'b0, 4'd0, 12'h001, 6'h2C, 16'h0138, 4'd0);
    cyc();
    chk("halt_v_o", v_o, 1);
    chk("halt_stall", stall_o, 1);
    issue(mk(6'h00, 4'd1, 4'd0, 2'b01, 16'h0007), 16'h013C);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("halted_v_%0d", i), v_o, 0);
      chk($sformatf("halted_stall_%0d", i), stall_o, 1);
    end

    // asynchronous reset in the middle of the halted state
    #1;
    rst = 1'b0;
    #1;
    chk("rst2_v_o", v_o, 0);
    chk("rst2_wb_o", wb_o, 0);
    chk("rst2_src_o", src_o, 0);
    chk("rst2_dopc_o", dopc_o, 0);
    chk("rst2_addr", origaddr_o, 0);
    chk("rst2_stall", stall_o, 0);
    cyc();
    rst = 1'b1;

    // register file was cleared by reset
    issue(mk(6'h00, 4'd3, 4'd2, 2'b00, 16'h0000), 16'h0200);
    expect_out(32'h0, 32'h0, 1'b1, 4'd3, 12'h800, 6'h00, 16'h0200, 4'd3);
    cyc();
    v_i = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
